// File: rtl/os_result_checker_if.sv
// Result-bus bundle shared by the golden and fault-injected OS arrays and the checker.
// The bench or upstream harness drives the master side; the checker samples the slave side.
interface os_result_checker_if #(
  parameter int D_W = 8,
  parameter int N   = 5
);
  logic                 start;
  logic [N-1:0]         valid_gold;
  logic [N-1:0]         valid_fault;
  logic [N*2*D_W-1:0]   m2_gold;
  logic [N*2*D_W-1:0]   m2_fault;

  modport master (output start, valid_gold, valid_fault, m2_gold, m2_fault);
  modport slave  (input  start, valid_gold, valid_fault, m2_gold, m2_fault);
endinterface

// File: rtl/os_result_checker.sv
// Compares golden and faulty OS-array result streams beat by beat and classifies the run
// as masked, SDC, control/valid error or timeout, with a first-error capture.
module os_result_checker #(
  parameter int D_W     = 8,
  parameter int N       = 5,
  parameter int M       = 5,
  parameter int DRAIN   = 100,
  parameter int TIMEOUT = 5000
) (
  input  logic                   clk,
  input  logic                   rst,
  os_result_checker_if.slave     bus,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             verdict,
  output logic [15:0]            mismatch_count,
  output logic [$clog2(N)-1:0]   first_err_row,
  output logic [31:0]            first_err_cycle,
  output logic [2*D_W-1:0]       first_err_gold,
  output logic [2*D_W-1:0]       first_err_fault,
  output logic                   first_err_valid,
  output logic [31:0]            cycle_cnt
);
  localparam int W   = 2 * D_W;
  localparam int T   = M * M / N;
  localparam int CW  = $clog2(T) + 1;
  localparam int RW  = $clog2(N);
  localparam int DCW = $clog2(DRAIN) + 1;
  localparam logic [CW-1:0] T_C = CW'(T);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    gold_cnt [N];
  logic [CW-1:0]    fault_cnt [N];
  logic [CW-1:0]    gold_cnt_nxt [N];
  logic [CW-1:0]    fault_cnt_nxt [N];
  logic [DCW-1:0]   drain_cnt;
  logic             sdc_flag, ctrl_flag;
  logic [N-1:0]     data_err, ctrl_err, err;
  logic             active, restart, gold_done, fault_done;
  logic             drain_exp, timeout_hit, enter_done;
  logic [RW-1:0]    err_row;
  logic [16:0]      mm_sum;
  logic [1:0]       verdict_nxt;

  always_comb begin
    active      = (state == S_RUN) || (state == S_DRAIN);
    restart     = bus.start && ((state == S_IDLE) || (state == S_DONE));
    gold_done   = 1'b1;
    fault_done  = 1'b1;
    data_err    = '0;
    ctrl_err    = '0;
    err_row     = '0;
    mm_sum      = {1'b0, mismatch_count};
    drain_exp   = 1'b0;
    timeout_hit = 1'b0;
    state_nxt   = state;
    for (int r = 0; r < N; r++) begin
      logic vg, vf, g_full, f_full;
      vg     = bus.valid_gold[r] & active;
      vf     = bus.valid_fault[r] & active;
      g_full = (gold_cnt[r] == T_C);
      f_full = (fault_cnt[r] == T_C);
      data_err[r] = vg & vf & (bus.m2_gold[r*W +: W] != bus.m2_fault[r*W +: W]);
      // A beat past the expected count is a control error even if both sides agree.
      ctrl_err[r] = (vg ^ vf) | (vg & g_full) | (vf & f_full);
      gold_cnt_nxt[r]  = (vg && !g_full) ? gold_cnt[r] + CW'(1) : gold_cnt[r];
      fault_cnt_nxt[r] = (vf && !f_full) ? fault_cnt[r] + CW'(1) : fault_cnt[r];
      gold_done  = gold_done  & (gold_cnt_nxt[r] == T_C);
      fault_done = fault_done & (fault_cnt_nxt[r] == T_C);
    end
    err = data_err | ctrl_err;
    for (int r = N - 1; r >= 0; r--) begin
      if (err[r]) err_row = RW'(r);
    end
    for (int r = 0; r < N; r++) mm_sum = mm_sum + 17'(err[r]);

    // Completion is judged on the post-increment counts so done follows the last beat directly.
    case (state)
      S_IDLE, S_DONE: if (restart) state_nxt = S_RUN;
      S_RUN: begin
        if (gold_done && fault_done) state_nxt = S_DONE;
        else if (gold_done)          state_nxt = S_DRAIN;
        else if (cycle_cnt == 32'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_DRAIN: begin
        if (fault_done) state_nxt = S_DONE;
        else if (drain_cnt == DCW'(DRAIN - 1)) begin
          drain_exp = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    enter_done = active && (state_nxt == S_DONE);
    if (timeout_hit)                              verdict_nxt = 2'd3;
    else if (ctrl_flag || (|ctrl_err) || drain_exp) verdict_nxt = 2'd2;
    else if (sdc_flag || (|data_err))             verdict_nxt = 2'd1;
    else                                          verdict_nxt = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || restart) begin
      for (int r = 0; r < N; r++) begin
        gold_cnt[r]  <= '0;
        fault_cnt[r] <= '0;
      end
      drain_cnt       <= '0;
      sdc_flag        <= 1'b0;
      ctrl_flag       <= 1'b0;
      verdict         <= '0;
      mismatch_count  <= '0;
      first_err_row   <= '0;
      first_err_cycle <= '0;
      first_err_gold  <= '0;
      first_err_fault <= '0;
      first_err_valid <= 1'b0;
      cycle_cnt       <= '0;
    end else if (active) begin
      for (int r = 0; r < N; r++) begin
        gold_cnt[r]  <= gold_cnt_nxt[r];
        fault_cnt[r] <= fault_cnt_nxt[r];
      end
      sdc_flag       <= sdc_flag | (|data_err);
      ctrl_flag      <= ctrl_flag | (|ctrl_err) | drain_exp;
      mismatch_count <= mm_sum[16] ? 16'hFFFF : mm_sum[15:0];
      if ((|err) && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_row   <= err_row;
        first_err_cycle <= cycle_cnt;
        first_err_gold  <= bus.m2_gold[err_row*W +: W];
        first_err_fault <= bus.m2_fault[err_row*W +: W];
      end
      if (!enter_done) cycle_cnt <= cycle_cnt + 32'd1;
      drain_cnt <= (state == S_RUN) ? '0 : drain_cnt + DCW'(1);
      if (enter_done) verdict <= verdict_nxt;
    end
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);
endmodule

// File: doc/os_result_checker.md
Name: os_result_checker

Overview:
- Downstream consumer of the dual OS systolic arrays (golden and fault-injected).
- Watches both result buses (m2 plus the per-row valid_m2) cycle by cycle and counts per-row output beats until the run completes.
- Produces a registered fault-outcome verdict, a mismatch count and a first-error capture.
- Replaces post-processing of logged text during fault campaigns with an in-simulation/in-fabric classifier.

Parameters:
- D_W, 8: operand width; result words are 2*D_W bits.
- N, 5: array dimension; number of result rows.
- M, 5: matrix dimension; each row must deliver M*M/N valid words per run.
- DRAIN, 100: cycles to wait after the golden run completes for faulty-side completion.
- TIMEOUT, 5000: maximum RUN cycles before a forced timeout verdict.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- valid_gold  in  N  per-row valid from the golden array.
- valid_fault  in  N  per-row valid from the faulty array.
- m2_gold  in  N*2*D_W  golden results, flattened; row r at bits [r*2*D_W +: 2*D_W].
- m2_fault  in  N*2*D_W  faulty results, same packing.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level, high in DONE.
- verdict  out  2  outcome code: 0 masked, 1 SDC, 2 control/valid error, 3 timeout.
- mismatch_count  out  16  row-level error events, saturating.
- first_err_row  out  $clog2(N)  row of the first error.
- first_err_cycle  out  32  cycle_cnt value at the first error.
- first_err_gold  out  2*D_W  m2_gold of that row at the first error.
- first_err_fault  out  2*D_W  m2_fault of that row at the first error.
- first_err_valid  out  1  high once a first error has been captured.
- cycle_cnt  out  32  RUN/DRAIN cycle counter.

Behaviour:
- Reset behaviour: rst asynchronously forces state IDLE and zeroes every output, every per-row counter and every sticky flag. Reset asserted mid-run aborts the run; no verdict is kept.
- States:
  - IDLE: waits for start.
  - RUN: monitors both buses.
  - DRAIN: golden complete, faulty not yet complete.
  - DONE: outputs held.
- Start and restart:
  - start in IDLE or DONE moves to RUN next cycle and clears counters, flags, captures and cycle_cnt.
  - start in RUN or DRAIN is ignored.
- cycle_cnt: 0 on the first RUN cycle; increments every RUN/DRAIN cycle; frozen in DONE.
- Per-row beat counters:
  - gold_cnt[r] and fault_cnt[r] are each $clog2(M*M/N)+1 bits wide.
  - Each increments on its own valid and saturates at T = M*M/N.
- Per-row error conditions, evaluated in RUN/DRAIN each cycle:
  - data_err[r]: valid_gold[r] & valid_fault[r] & (m2_gold row != m2_fault row).
  - ctrl_err[r]: valid_gold[r] ^ valid_fault[r], or any valid on a side whose counter is already at T.
  - err[r] = data_err[r] | ctrl_err[r].
- Sticky flags: sdc_flag sets on any data_err; ctrl_flag sets on any ctrl_err.
- mismatch_count: adds popcount(err) each cycle; saturates at 16'hFFFF and never wraps.
- First-error capture:
  - Taken on the first cycle with any err bit while first_err_valid=0.
  - Captures the lowest erroring row index, the current cycle_cnt, and the raw m2_gold/m2_fault words of that row.
  - first_err_valid is set on the same edge; later errors never overwrite the capture.
- Completion:
  - gold_done = all gold_cnt == T; fault_done = all fault_cnt == T.
  - RUN: gold_done & fault_done go to DONE. gold_done alone goes to DRAIN with the drain counter at 0; the drain counter increments in each DRAIN cycle, sets ctrl_flag on expiry and goes to DONE.
  - DRAIN: fault_done goes to DONE; drain counter reaching DRAIN-1 also goes to DONE.
- Timeout: in RUN, when cycle_cnt reaches TIMEOUT-1 without gold_done, the FSM goes to DONE with the timeout verdict.
- Verdict is registered on the DONE entry edge. Priority: timeout (3) > ctrl_flag (2) > sdc_flag (1) > masked (0).
- Same-cycle boundary: completion and an error on the same cycle are both counted before the verdict is formed.
- Latency: done rises on the edge after the last required valid is sampled. done and verdict hold until start or rst.

Test Plan:
- Identical streams, T=5: all 5 rows valid for 5 consecutive cycles with equal data, starting one cycle after start -> done rises on the edge after the 5th beat; verdict=0; mismatch_count=0; first_err_valid=0.
- Data corruption: row 2, 3rd beat (cycle_cnt=2), gold 16'h0010 vs fault 16'h0090 -> verdict=1; mismatch_count=1; first_err_row=2; first_err_cycle=2; first_err_gold=16'h0010; first_err_fault=16'h0090.
- Simultaneous errors: rows 1 and 3 differ on the same beat, row 4 differs later -> mismatch_count=3; first_err_row=1; capture unchanged by the later error.
- Missing faulty beat: valid_fault[4] dropped on one beat -> ctrl error counted; golden completes, FSM enters DRAIN, done after 100 drain cycles; verdict=2.
- Timeout: TIMEOUT=50, no valids after start -> done with cycle_cnt=49; verdict=3.
- Reset and restart: rst pulsed mid-RUN -> all outputs 0 asynchronously, before the next clock edge. A new start with an identical stream -> verdict=0. start asserted during RUN -> no effect on counters.
